// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch stage with a decoupling fetch queue
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4,
  parameter int          IM_WORDS = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_addr,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc4,
  output logic [31:0]                  out_inst,
  output logic                         out_fault,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Range bounds carry an extra bit so RESET_PC + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] RANGE_LO = {1'b0, RESET_PC};
  localparam logic [32:0] RANGE_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } mode_t;

  logic [31:0]   fpc_q, fpc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  mode_t         mode_q, mode_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] inst_mem_q  [DEPTH];
  logic        fault_mem_q [DEPTH];

  logic fault_now;
  logic queue_empty;
  logic queue_full;
  logic push;
  logic pop;

  always_comb begin
    fault_now   = (fpc_q[1:0] != 2'b00)
               || ({1'b0, fpc_q} <  RANGE_LO)
               || ({1'b0, fpc_q} >= RANGE_HI);
    queue_empty = (count_q == '0);
    queue_full  = (count_q == CW'(DEPTH));
    push        = (mode_q == FETCH) && !queue_full && !redirect_valid;
    pop         = !queue_empty && out_ready;
  end

  always_comb begin
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mode_d  = mode_q;

    if (redirect_valid) begin
      // A pop in this cycle is seen by the consumer but the flush wipes it anyway.
      fpc_d   = redirect_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      mode_d  = FETCH;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        if (fault_now) begin
          mode_d = HALT;
        end else begin
          fpc_d = fpc_q + 32'd4;
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mode_q  <= FETCH;
    end else begin
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Payload storage needs no reset: empty slots are never visible on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= fpc_q;
      inst_mem_q[tail_q]  <= fault_now ? 32'h0 : imem_rdata;
      fault_mem_q[tail_q] <= fault_now;
    end
  end

  assign imem_addr = fpc_q;
  assign count     = count_q;
  assign out_valid = !queue_empty;
  assign out_pc    = queue_empty ? 32'h0 : pc_mem_q[head_q];
  assign out_pc4   = queue_empty ? 32'h0 : pc_mem_q[head_q] + 32'd4;
  assign out_inst  = queue_empty ? 32'h0 : inst_mem_q[head_q];
  assign out_fault = queue_empty ? 1'b0  : fault_mem_q[head_q];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IM_WORDS = 4096;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_pc4, out_inst;
  logic        out_fault;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  inst_fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst), .out_fault(out_fault), .count(count)
  );

  // Reference model: a plain queue of fetched entries plus fetch PC and halt flag.
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_halt;

  typedef struct {
    logic rv; logic [31:0] ra; logic rdy;
    logic ev; logic [31:0] epc; logic ef; int ec; logic [31:0] eimem;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc  = RST_PC;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] ra, input logic rdy);
    int old_n;
    logic flt;
    longint unsigned a;
    old_n = mq.size();
    if (rv) begin
      mq.delete();
      m_fpc  = ra;
      m_halt = 1'b0;
    end else begin
      if (old_n > 0 && rdy) void'(mq.pop_front());
      if (!m_halt && old_n < DEPTH) begin
        a   = longint'(m_fpc);
        flt = (m_fpc % 4 != 0) || a < longint'(RST_PC) || a >= longint'(RST_PC) + 4 * IM_WORDS;
        mq.push_back('{m_fpc, flt ? 32'h0 : mem_word(m_fpc), flt});
        if (flt) m_halt = 1'b1;
        else     m_fpc  = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic model_check();
    logic ev;
    ev = (mq.size() > 0);
    chk("imem_addr", imem_addr, m_fpc);
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_pc", out_pc, ev ? mq[0].pc : 32'h0);
    chk("out_pc4", out_pc4, ev ? mq[0].pc + 32'd4 : 32'h0);
    chk("out_inst", out_inst, ev ? mq[0].inst : 32'h0);
    chk("out_fault", 32'(out_fault), ev ? 32'(mq[0].fault) : 32'h0);
  endtask

  // Called at posedge+1: apply inputs, check current outputs, clock, advance model.
  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rdy);
    redirect_valid = rv;
    redirect_addr  = ra;
    out_ready      = rdy;
    model_check();
    @(posedge clk);
    model_step(rv, ra, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          rv    ra            rdy   ev    epc           ef    ec  eimem
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 0, 32'h3000};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3000,     1'b0, 1, 32'h3004};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3000,     1'b0, 2, 32'h3008};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3000,     1'b0, 3, 32'h300C};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3000,     1'b0, 4, 32'h3010};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3000,     1'b0, 4, 32'h3010};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3004,     1'b0, 3, 32'h3010};
    vecs[7]  = '{1'b1, 32'h3400,     1'b1, 1'b1, 32'h3008,     1'b0, 3, 32'h3014};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h3400};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3400,     1'b0, 1, 32'h3404};
    vecs[10] = '{1'b1, 32'h3402,     1'b1, 1'b1, 32'h3404,     1'b0, 1, 32'h3408};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h3402};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3402,     1'b1, 1, 32'h3402};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h3402};
    vecs[14] = '{1'b1, 32'h6FFC,     1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h3402};
    vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 0, 32'h6FFC};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h6FFC,     1'b0, 1, 32'h7000};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h6FFC,     1'b0, 2, 32'h7000};
    vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h7000,     1'b1, 1, 32'h7000};
    vecs[19] = '{1'b1, 32'h3000,     1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h7000};
    vecs[20] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h3000};
    vecs[21] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3000,     1'b0, 1, 32'h3004};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.pc", i), out_pc, vecs[i].epc);
      chk($sformatf("v%0d.pc4", i), out_pc4, vecs[i].ev ? vecs[i].epc + 32'd4 : 32'h0);
      chk($sformatf("v%0d.inst", i), out_inst,
          (vecs[i].ev && !vecs[i].ef) ? mem_word(vecs[i].epc) : 32'h0);
      chk($sformatf("v%0d.fault", i), 32'(out_fault), 32'(vecs[i].ef));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].ec));
      chk($sformatf("v%0d.imem", i), imem_addr, vecs[i].eimem);
      cycle(vecs[i].rv, vecs[i].ra, vecs[i].rdy);
    end

    // Full-queue drain: 0x3000..0x300C in order, then 0x3010 with no gap.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.imem", imem_addr, 32'h3010);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("drain%0d.pc", i), out_pc, 32'h3000 + 32'(4 * i));
      chk($sformatf("drain%0d.valid", i), 32'(out_valid), 32'd1);
      cycle(1'b0, 32'h0, 1'b1);
    end

    // Asynchronous reset mid-cycle with two entries queued.
    do_reset();
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("prereset.count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset.count", 32'(count), 32'd0);
    chk("areset.valid", 32'(out_valid), 32'd0);
    chk("areset.pc", out_pc, 32'h0);
    chk("areset.pc4", out_pc4, 32'h0);
    chk("areset.inst", out_inst, 32'h0);
    chk("areset.imem", imem_addr, 32'h3000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1);
    chk("restart.pc", out_pc, 32'h3000);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] ra;
      rv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: ra = 32'h3000 + 32'($urandom_range(0, 30)) * 4;
        1: ra = 32'h6FF0 + 32'($urandom_range(0, 4)) * 4;
        2: ra = 32'h2FFC;
        3: ra = 32'h3001 + 32'($urandom_range(0, 2));
        4: ra = $urandom();
        default: ra = 32'hFFFF_FFFC;
      endcase
      cycle(rv, ra, $urandom_range(0, 3) != 0);
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
